// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives a ready/ack data-memory bus from EX/MEM and owns the MEM/WB register.
// Optional bus-timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_MemtoReg,
    input  logic              MEM_RegWrite,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [ADDR_W-1:0] alu_result_to_mem,
    input  logic [DATA_W-1:0] write_data_to_mem,
    input  logic [4:0]        write_reg_to_mem,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              WB_MemtoReg,
    output logic              WB_RegWrite,
    output logic [DATA_W-1:0] read_data_to_wb,
    output logic [ADDR_W-1:0] alu_result_to_wb,
    output logic [4:0]        write_reg_to_wb,
    output logic              mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state;
    logic   op;
    logic   is_load;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_range_check
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign op      = MEM_MemRead | MEM_MemWrite;
    // A combined read+write request is treated as a store, so it never captures read data.
    assign is_load = MEM_MemRead & ~MEM_MemWrite;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] count;
    assign timeout_hit = (state == S_WAIT) && (count == 8'(TIMEOUT_CYCLES - 1)) && !dmem_ack;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // Releasing in the completion cycle lets EX/MEM advance on the same edge MEM/WB captures.
    assign mem_stall = op & ~((state == S_WAIT) & (dmem_ack | timeout_hit));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            WB_MemtoReg      <= 1'b0;
            WB_RegWrite      <= 1'b0;
            read_data_to_wb  <= '0;
            alu_result_to_wb <= '0;
            write_reg_to_wb  <= '0;
`ifdef MEM_TIMEOUT_EN
            count            <= '0;
            mem_err          <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            mem_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (op) begin
                        state       <= S_WAIT;
                        dmem_req    <= 1'b1;
                        dmem_we     <= MEM_MemWrite;
                        dmem_addr   <= alu_result_to_mem;
                        dmem_wdata  <= write_data_to_mem;
                        WB_MemtoReg <= 1'b0;
                        WB_RegWrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        count       <= '0;
`endif
                    end else begin
                        WB_MemtoReg      <= MEM_MemtoReg;
                        WB_RegWrite      <= MEM_RegWrite;
                        alu_result_to_wb <= alu_result_to_mem;
                        write_reg_to_wb  <= write_reg_to_mem;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state            <= S_IDLE;
                        dmem_req         <= 1'b0;
                        WB_MemtoReg      <= MEM_MemtoReg;
                        WB_RegWrite      <= MEM_RegWrite;
                        alu_result_to_wb <= alu_result_to_mem;
                        write_reg_to_wb  <= write_reg_to_mem;
                        if (is_load) read_data_to_wb <= dmem_rdata;
                    end else if (timeout_hit) begin
                        // Aborted access retires without a register write.
                        state            <= S_IDLE;
                        dmem_req         <= 1'b0;
                        WB_MemtoReg      <= MEM_MemtoReg;
                        WB_RegWrite      <= 1'b0;
                        alu_result_to_wb <= alu_result_to_mem;
                        write_reg_to_wb  <= write_reg_to_mem;
`ifdef MEM_TIMEOUT_EN
                        mem_err          <= 1'b1;
`endif
                    end else begin
                        WB_MemtoReg <= 1'b0;
                        WB_RegWrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        count       <= count + 8'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
